// File: rtl/carousel_rx_align_if.sv
// Lane bus for carousel_rx_align: per-lane valid/ready input and output sides plus rotation index.
// Optional batch_count is present only when CAROUSEL_RX_BATCH_COUNT_EN is defined.
interface carousel_rx_align_if #(
   parameter int NUM_LANES  = 3,
   parameter int DATA_WIDTH = 8
);
   localparam int ROT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic [NUM_LANES*DATA_WIDTH-1:0] data_in;
   logic [NUM_LANES-1:0]            data_in_valid;
   logic [NUM_LANES-1:0]            data_in_ready;
   logic [NUM_LANES*DATA_WIDTH-1:0] data_out;
   logic [NUM_LANES-1:0]            data_out_valid;
   logic [NUM_LANES-1:0]            data_out_ready;
   logic [ROT_W-1:0]                rot_offset;
`ifdef CAROUSEL_RX_BATCH_COUNT_EN
   logic [31:0]                     batch_count;
`endif

   modport slave (
      input  data_in, data_in_valid, data_out_ready,
      output data_in_ready, data_out, data_out_valid, rot_offset
`ifdef CAROUSEL_RX_BATCH_COUNT_EN
      , output batch_count
`endif
   );

   modport master (
      output data_in, data_in_valid, data_out_ready,
      input  data_in_ready, data_out, data_out_valid, rot_offset
`ifdef CAROUSEL_RX_BATCH_COUNT_EN
      , input  batch_count
`endif
   );
endinterface

// File: rtl/carousel_rx_align.sv
// Collects one beat per lane, then drains them de-rotated; 1 cycle capture->valid, 1 batch per 2 cycles.
// Per-lane backpressure on both sides; optional batch counter under CAROUSEL_RX_BATCH_COUNT_EN.
module carousel_rx_align #(
   parameter int NUM_LANES  = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   carousel_rx_align_if.slave  bus
);
   localparam int ROT_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(NUM_LANES - 1);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t                          state_q, state_d;
   logic [NUM_LANES-1:0]            captured_q, captured_d;
   logic [NUM_LANES-1:0]            dispensed_q, dispensed_d;
   logic [ROT_W-1:0]                rot_q, rot_d;
   logic [NUM_LANES*DATA_WIDTH-1:0] lane_q, lane_d;
   logic [NUM_LANES-1:0]            in_hs, out_hs;
   logic                            batch_done;

   assign in_hs  = bus.data_in_valid & bus.data_in_ready;
   assign out_hs = bus.data_out_valid & bus.data_out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= COLLECT;
         captured_q  <= '0;
         dispensed_q <= '0;
         rot_q       <= '0;
         lane_q      <= '0;
      end else begin
         state_q     <= state_d;
         captured_q  <= captured_d;
         dispensed_q <= dispensed_d;
         rot_q       <= rot_d;
         lane_q      <= lane_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      captured_d  = captured_q;
      dispensed_d = dispensed_q;
      rot_d       = rot_q;
      lane_d      = lane_q;
      batch_done  = 1'b0;
      case (state_q)
         COLLECT: begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (in_hs[i]) begin
                  lane_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
                  captured_d[i] = 1'b1;
               end
            end
            if (&captured_d) state_d = DRAIN;
         end
         DRAIN: begin
            dispensed_d = dispensed_q | out_hs;
            if (&dispensed_d) begin
               batch_done  = 1'b1;
               state_d     = COLLECT;
               captured_d  = '0;
               dispensed_d = '0;
               rot_d       = (rot_q == ROT_LAST) ? '0 : rot_q + 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Output lane j shows the register of source lane (j - k) mod N; kept non-negative.
   always_comb begin
      int src;
      src                = 0;
      bus.data_in_ready  = '0;
      bus.data_out_valid = '0;
      bus.data_out       = '0;
      bus.rot_offset     = rot_q;
      if (state_q == COLLECT) bus.data_in_ready  = ~captured_q;
      else                    bus.data_out_valid = ~dispensed_q;
      for (int j = 0; j < NUM_LANES; j++) begin
         src = (j + NUM_LANES - int'(rot_q)) % NUM_LANES;
         bus.data_out[j*DATA_WIDTH +: DATA_WIDTH] = lane_q[src*DATA_WIDTH +: DATA_WIDTH];
      end
   end

`ifdef CAROUSEL_RX_BATCH_COUNT_EN
   logic [31:0] batch_count_q, batch_count_d;

   always_comb begin
      batch_count_d = batch_count_q;
      if (batch_done && batch_count_q != 32'hFFFF_FFFF) batch_count_d = batch_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) batch_count_q <= '0;
      else      batch_count_q <= batch_count_d;
   end

   assign bus.batch_count = batch_count_q;
`else
   logic unused_batch_done;
   assign unused_batch_done = batch_done;
`endif
endmodule

// File: tb/tb_carousel_rx_align.sv
// Directed table-driven bench for carousel_rx_align (3 lanes x 8 bits), plus reset and batch-run sequences.
module tb_carousel_rx_align;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   carousel_rx_align_if #(.NUM_LANES(3), .DATA_WIDTH(8)) bus();

   carousel_rx_align #(.NUM_LANES(3), .DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] din;
      logic [2:0]  vin;
      logic [2:0]  ordy;
      logic [2:0]  e_ov;
      logic [2:0]  e_ir;
      logic [23:0] e_dout;
      logic [1:0]  e_rot;
      bit          chk_dat;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      // din packs {lane2, lane1, lane0}; expected outputs are seen after the clock edge
      vecs[0]  = '{24'h121110, 3'b111, 3'b111, 3'b111, 3'b000, 24'h121110, 2'd0, 1'b1};
      vecs[1]  = '{24'h000000, 3'b000, 3'b111, 3'b000, 3'b111, 24'h000000, 2'd1, 1'b0};
      vecs[2]  = '{24'hB0B2B1, 3'b111, 3'b111, 3'b111, 3'b000, 24'hB2B1B0, 2'd1, 1'b1};
      vecs[3]  = '{24'h000000, 3'b000, 3'b111, 3'b000, 3'b111, 24'h000000, 2'd2, 1'b0};
      vecs[4]  = '{24'hC1C0C2, 3'b111, 3'b111, 3'b111, 3'b000, 24'hC2C1C0, 2'd2, 1'b1};
      vecs[5]  = '{24'h000000, 3'b000, 3'b111, 3'b000, 3'b111, 24'h000000, 2'd0, 1'b0};
      vecs[6]  = '{24'h222120, 3'b100, 3'b111, 3'b000, 3'b011, 24'h000000, 2'd0, 1'b0};
      vecs[7]  = '{24'hEE2120, 3'b100, 3'b111, 3'b000, 3'b011, 24'h000000, 2'd0, 1'b0};
      vecs[8]  = '{24'hEE2120, 3'b000, 3'b111, 3'b000, 3'b011, 24'h000000, 2'd0, 1'b0};
      vecs[9]  = '{24'hEE2120, 3'b001, 3'b111, 3'b000, 3'b010, 24'h000000, 2'd0, 1'b0};
      vecs[10] = '{24'hEE2120, 3'b000, 3'b111, 3'b000, 3'b010, 24'h000000, 2'd0, 1'b0};
      vecs[11] = '{24'hEE2120, 3'b010, 3'b000, 3'b111, 3'b000, 24'h222120, 2'd0, 1'b1};
      vecs[12] = '{24'h555555, 3'b111, 3'b010, 3'b101, 3'b000, 24'h222120, 2'd0, 1'b1};
      vecs[13] = '{24'h555555, 3'b111, 3'b010, 3'b101, 3'b000, 24'h222120, 2'd0, 1'b1};
      vecs[14] = '{24'h555555, 3'b111, 3'b010, 3'b101, 3'b000, 24'h222120, 2'd0, 1'b1};
      vecs[15] = '{24'h555555, 3'b111, 3'b010, 3'b101, 3'b000, 24'h222120, 2'd0, 1'b1};
      vecs[16] = '{24'h555555, 3'b000, 3'b001, 3'b100, 3'b000, 24'h222120, 2'd0, 1'b1};
      vecs[17] = '{24'h000000, 3'b000, 3'b100, 3'b000, 3'b111, 24'h000000, 2'd1, 1'b0};
      vecs[18] = '{24'h323130, 3'b111, 3'b000, 3'b111, 3'b000, 24'h313032, 2'd1, 1'b1};
      vecs[19] = '{24'h000000, 3'b000, 3'b001, 3'b110, 3'b000, 24'h313032, 2'd1, 1'b1};

      rst                = 1'b0;
      bus.data_in        = '0;
      bus.data_in_valid  = '0;
      bus.data_out_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(bus.data_out_valid), 32'h0);
      chk("reset in_ready",  32'(bus.data_in_ready),  32'h7);
      chk("reset rot",       32'(bus.rot_offset),     32'h0);
      chk("reset data_out",  32'(bus.data_out),       32'h0);
      rst = 1'b1;

      for (int v = 0; v < 20; v++) begin
         bus.data_in        = vecs[v].din;
         bus.data_in_valid  = vecs[v].vin;
         bus.data_out_ready = vecs[v].ordy;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", v), 32'(bus.data_out_valid), 32'(vecs[v].e_ov));
         chk($sformatf("v%0d in_ready", v),  32'(bus.data_in_ready),  32'(vecs[v].e_ir));
         chk($sformatf("v%0d rot", v),       32'(bus.rot_offset),     32'(vecs[v].e_rot));
         if (vecs[v].chk_dat)
            chk($sformatf("v%0d data_out", v), 32'(bus.data_out), 32'(vecs[v].e_dout));
      end

      // Reset in the middle of a drain: pending output handshakes must be lost
      rst                = 1'b0;
      bus.data_out_ready = 3'b111;
      @(posedge clk);
      #1;
      chk("midrst out_valid", 32'(bus.data_out_valid), 32'h0);
      chk("midrst in_ready",  32'(bus.data_in_ready),  32'h7);
      chk("midrst rot",       32'(bus.rot_offset),     32'h0);
      chk("midrst data_out",  32'(bus.data_out),       32'h0);
      rst = 1'b1;

      // Five back-to-back full batches with everything held high
      bus.data_in        = 24'h0A0B0C;
      bus.data_in_valid  = 3'b111;
      bus.data_out_ready = 3'b111;
      @(posedge clk);
      #1;
      chk("run first drain valid", 32'(bus.data_out_valid), 32'h7);
      repeat (9) @(posedge clk);
      #1;
      chk("run rot",       32'(bus.rot_offset),     32'h2);
      chk("run out_valid", 32'(bus.data_out_valid), 32'h0);
      chk("run in_ready",  32'(bus.data_in_ready),  32'h7);
`ifdef CAROUSEL_RX_BATCH_COUNT_EN
      chk("run batch_count", bus.batch_count, 32'd5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
